// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_N         = 4;
    localparam int DEF_W         = 4;
    localparam int DEF_MAX_BURST = 4;

    // Bits needed to index v items; never returns 0 so vectors stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle; master = arbiter, slave = producers + FIFO.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           fifo_full;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_data
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_data
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping mod N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = clog2(DEF_N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among N producers.
// Optional stall counter enabled by FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  N         = DEF_N,
    parameter int  W         = DEF_W,
    parameter int  MAX_BURST = DEF_MAX_BURST,
    localparam int IW        = clog2(N),
    localparam int CW        = clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus,
    output logic [IW-1:0]     owner,
    output logic              busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    input  logic              stall_clr,
    output logic [15:0]       stall_cnt
`endif
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          cont;
    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt;
    logic [W-1:0]  fifo_data;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign cont = (state_q == BURST) && bus.req[owner_q] && (int'(burst_cnt_q) < MAX_BURST);

    // A full FIFO freezes everything, so a stalled owner resumes its burst intact.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt_vld     = 1'b0;
        gnt_idx     = owner_q;
        if (bus.fifo_full) begin
            gnt_vld = 1'b0;
        end else if (cont) begin
            gnt_vld     = 1'b1;
            burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (pick_vld) begin
            gnt_vld     = 1'b1;
            gnt_idx     = pick_idx;
            owner_d     = pick_idx;
            burst_cnt_d = CW'(1);
            rr_ptr_d    = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
            state_d     = BURST;
        end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end
    end

    // Grant is combinational off req, so reset must mask it explicitly.
    always_comb begin
        gnt       = '0;
        fifo_data = '0;
        if (rst && gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
            fifo_data    = bus.req_data[gnt_idx*W +: W];
        end
    end

    assign bus.gnt        = gnt;
    assign bus.fifo_wr_en = |gnt;
    assign bus.fifo_data  = fifo_data;
    assign owner          = owner_q;
    assign busy           = (state_q == BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr)
            stall_cnt_d = '0;
        else if ((|bus.req) && bus.fifo_full && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
